alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Issue controller for the ALU. Accepts one op plus operands on a valid/ready request port and registers them.
//  Drives ALU operands and a one-hot select for the op's execute window, then captures z/hi/lo.
//  Returns the result on a valid/ready response port. Sits between the control unit and the ALU.
//  Mul/div get configurable multi-cycle windows, so a sequential divider can replace the combinational one.
// PARAMETERS
//  WIDTH       32  operand/result width
//  MUL_CYCLES  1   execute-window cycles for op 8 (mul); >=1
//  DIV_CYCLES  32  execute-window cycles for op 9 (div); >=1
// PORTS
//  clk         in   1      clock, all state on rising edge
//  clr         in   1      asynchronous active-low reset
//  req_valid   in   1      request present
//  req_ready   out  1      request accepted when req_valid & req_ready
//  req_op      in   4      op index: 0 add,1 sub,2 shr,3 shl,4 ror,5 rol,6 and,7 or,8 mul,9 div,10 neg,11 not
//  req_a       in   WIDTH  operand a
//  req_b       in   WIDTH  operand b
//  alu_a       out  WIDTH  registered operand a to ALU
//  alu_b       out  WIDTH  registered operand b to ALU
//  alu_select  out  12     one-hot ALU select, bit = op index; all-zero outside EXEC
//  alu_z       in   WIDTH  ALU z result
//  alu_hi      in   WIDTH  ALU hi result (mul/div)
//  alu_lo      in   WIDTH  ALU lo result (mul/div)
//  rsp_valid   out  1      response present
//  rsp_ready   in   1      response consumed when rsp_valid & rsp_ready
//  rsp_z       out  WIDTH  captured z (0 for mul/div/illegal)
//  rsp_hi      out  WIDTH  captured hi (0 unless mul/div)
//  rsp_lo      out  WIDTH  captured lo (0 unless mul/div)
//  rsp_wide    out  1      1 when response is mul/div (hi/lo meaningful)
//  rsp_err     out  1      1 when req_op >= 12 (illegal)
// BEHAVIOUR
//  Reset: async on clr=0; state IDLE, counter 0, every output 0 (req_ready=0 while clr=0).
//   req_ready goes 1 on the first edge after release.
//  States: IDLE -> EXEC -> DONE -> IDLE, or DONE -> EXEC directly.
//  IDLE: req_ready=1. On accept, latch op/a/b into alu_a/alu_b.
//   Load counter = MUL_CYCLES-1 (op 8), DIV_CYCLES-1 (op 9), else 0. Go to EXEC.
//   Illegal op: skip EXEC, go straight to DONE with rsp_err=1 and all data 0.
//  EXEC: alu_select = 1<<op, held stable whole window; alu_a/alu_b held stable.
//   Counter decrements each cycle. At counter==0, capture alu_z/hi/lo into rsp_* and go to DONE.
//   Captured fields are masked per op as specified in PORTS.
//  Latency: accept edge T0; EXEC occupies N cycles (1, MUL_CYCLES or DIV_CYCLES); rsp_valid=1 from edge T0+N.
//  DONE: rsp_valid=1; rsp_* stable until handshake. req_ready = rsp_ready (same-cycle consume + accept).
//   Consume with no new accept -> IDLE, rsp_valid=0, rsp_* keep last values.
//   Consume and accept in the same cycle -> EXEC for the new op; no bubble in req_ready.
//  req_ready=0 throughout EXEC and in DONE while rsp_ready=0; requests never dropped or reordered.
//  req_* ignored when not accepted; request changes during EXEC have no effect.
//  Reset mid-EXEC or mid-DONE: op abandoned, no response emitted, outputs 0 immediately.
// TESTING
//  add a=124 b=7 -> alu_select=12'h001 one cycle; rsp_valid 1 cycle after EXEC, rsp_z=131, rsp_wide=0
//  mul a=124 b=7, MUL_CYCLES=3 -> select 12'h100 for 3 cycles; rsp_lo=868 rsp_hi=0 rsp_z=0 rsp_wide=1
//  sub response with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_z=117 stable; req_ready=0 throughout
//  back-to-back and(7C,7) then or(7C,7), rsp_ready=1 -> rsp_z 00000004 then 0000007f; no idle cycle
//  req_op=13 -> rsp_err=1, rsp_z/hi/lo=0, alu_select never nonzero, rsp_valid 1 cycle after accept
//  div DIV_CYCLES=32, clr=0 at cycle 10 of EXEC -> outputs 0 at once; after release fresh not(7C) gives ffffff83

Source files
------------

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Issue controller for the ALU. Takes a request, runs the selected
//            operation for its execute window, then returns the captured result.
// Revision : 1.0
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [11:0]      alu_select_o,
    input  logic [WIDTH-1:0] alu_z_i,
    input  logic [WIDTH-1:0] alu_hi_i,
    input  logic [WIDTH-1:0] alu_lo_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_z_o,
    output logic [WIDTH-1:0] rsp_hi_o,
    output logic [WIDTH-1:0] rsp_lo_o,
    output logic             rsp_wide_o,
    output logic             rsp_err_o
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               up_q;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   z_q, z_d, hi_q, hi_d, lo_q, lo_d;
    logic               wide_q, wide_d, err_q, err_d;
    logic               w_accept;
    logic               w_op_wide;

    // up_q keeps req_ready low until the first edge after reset release
    assign req_ready_o = up_q && ((state_q == S_IDLE) ||
                                  ((state_q == S_DONE) && rsp_ready_i));
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_op_wide   = (op_q == 4'd8) || (op_q == 4'd9);

    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign rsp_valid_o = (state_q == S_DONE);
    assign rsp_z_o     = z_q;
    assign rsp_hi_o    = hi_q;
    assign rsp_lo_o    = lo_q;
    assign rsp_wide_o  = wide_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        z_d          = z_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        wide_d       = wide_q;
        err_d        = err_q;
        alu_select_o = '0;

        case (state_q)
            S_EXEC: begin
                alu_select_o = 12'b1 << op_q;
                if (cnt_q == '0) begin
                    z_d     = w_op_wide ? '0 : alu_z_i;
                    hi_d    = w_op_wide ? alu_hi_i : '0;
                    lo_d    = w_op_wide ? alu_lo_i : '0;
                    wide_d  = w_op_wide;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // Acceptance only happens in IDLE or while DONE is being consumed
        if (w_accept) begin
            op_d = req_op_i;
            a_d  = req_a_i;
            b_d  = req_b_i;
            if (req_op_i >= 4'd12) begin
                z_d     = '0;
                hi_d    = '0;
                lo_d    = '0;
                wide_d  = 1'b0;
                err_d   = 1'b1;
                cnt_d   = '0;
                state_d = S_DONE;
            end else begin
                if (req_op_i == 4'd8) begin
                    cnt_d = CNT_W'(MUL_CYCLES - 1);
                end else if (req_op_i == 4'd9) begin
                    cnt_d = CNT_W'(DIV_CYCLES - 1);
                end else begin
                    cnt_d = '0;
                end
                state_d = S_EXEC;
            end
        end
    end

    always_ff @(posedge clk_i or negedge clr_i) begin
        if (!clr_i) begin
            state_q <= S_IDLE;
            up_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            wide_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= 1'b1;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wide_q  <= wide_d;
            err_q   <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Directed self-checking bench for alu_sequencer with a small ALU model.
// Revision : 1.0
// ============================================================================
module tb_alu_sequencer;

    localparam int WIDTH = 32;

    logic             clk;
    logic             clr;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a, req_b;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [11:0]      alu_select;
    logic [WIDTH-1:0] alu_z, alu_hi, alu_lo;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z, rsp_hi, rsp_lo;
    logic             rsp_wide, rsp_err;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.WIDTH(WIDTH), .MUL_CYCLES(3), .DIV_CYCLES(32)) dut (
        .clk_i(clk), .clr_i(clr),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_select_o(alu_select),
        .alu_z_i(alu_z), .alu_hi_i(alu_hi), .alu_lo_i(alu_lo),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_z_o(rsp_z), .rsp_hi_o(rsp_hi), .rsp_lo_o(rsp_lo),
        .rsp_wide_o(rsp_wide), .rsp_err_o(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU model: junk on unused fields so that masking in the sequencer is visible
    always_comb begin
        logic [63:0] prod;
        prod   = 64'(alu_a) * 64'(alu_b);
        alu_z  = 32'hDEAD_BEEF;
        alu_hi = 32'h0000_1234;
        alu_lo = 32'h0000_5678;
        case (alu_select)
            12'h001: alu_z = alu_a + alu_b;
            12'h002: alu_z = alu_a - alu_b;
            12'h040: alu_z = alu_a & alu_b;
            12'h080: alu_z = alu_a | alu_b;
            12'h800: alu_z = ~alu_a;
            12'h100: begin alu_hi = prod[63:32]; alu_lo = prod[31:0]; end
            12'h200: begin
                alu_hi = (alu_b != 0) ? alu_a % alu_b : '0;
                alu_lo = (alu_b != 0) ? alu_a / alu_b : '0;
            end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        #2;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (alu_select !== 12'h000) begin errors++; $display("FAIL rst_select got %h exp 000", alu_select); end
        checks++; if (alu_a !== '0 || rsp_z !== '0 || rsp_err !== 1'b0) begin errors++; $display("FAIL rst_data got a=%h z=%h err=%b exp 0", alu_a, rsp_z, rsp_err); end
        tick(); tick();
        clr = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got %b exp 0", req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_add();
        req_valid = 1'b1; req_op = 4'd0; req_a = 32'd124; req_b = 32'd7; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0; req_op = 4'd1; req_a = 32'd999;
        checks++; if (alu_select !== 12'h001) begin errors++; $display("FAIL add_select got %h exp 001", alu_select); end
        checks++; if (alu_a !== 32'd124 || alu_b !== 32'd7) begin errors++; $display("FAIL add_operands got %0d/%0d exp 124/7", alu_a, alu_b); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL add_exec_flags got v=%b r=%b exp 0/0", rsp_valid, req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_z !== 32'd131 || rsp_wide !== 1'b0 || rsp_hi !== '0 || rsp_lo !== '0) begin errors++; $display("FAIL add_rsp got z=%0d w=%b hi=%h lo=%h exp 131/0/0/0", rsp_z, rsp_wide, rsp_hi, rsp_lo); end
        checks++; if (alu_select !== 12'h000) begin errors++; $display("FAIL add_select_done got %h exp 000", alu_select); end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL add_consume got v=%b r=%b exp 0/1", rsp_valid, req_ready); end
        checks++; if (rsp_z !== 32'd131) begin errors++; $display("FAIL add_rsp_hold got %0d exp 131", rsp_z); end
    endtask

    task automatic test_mul();
        req_valid = 1'b1; req_op = 4'd8; req_a = 32'd124; req_b = 32'd7; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (alu_select !== 12'h100 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mul_window%0d got sel=%h v=%b exp 100/0", i, alu_select, rsp_valid); end
            tick();
        end
        checks++; if (rsp_valid !== 1'b1 || alu_select !== 12'h000) begin errors++; $display("FAIL mul_done got v=%b sel=%h exp 1/000", rsp_valid, alu_select); end
        checks++; if (rsp_lo !== 32'd868 || rsp_hi !== '0 || rsp_z !== '0 || rsp_wide !== 1'b1) begin errors++; $display("FAIL mul_rsp got lo=%0d hi=%h z=%h w=%b exp 868/0/0/1", rsp_lo, rsp_hi, rsp_z, rsp_wide); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_illegal();
        req_valid = 1'b1; req_op = 4'd13; req_a = 32'd124; req_b = 32'd7; rsp_ready = 1'b0;
        checks++; if (alu_select !== 12'h000) begin errors++; $display("FAIL ill_select_pre got %h exp 000", alu_select); end
        tick();
        req_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || alu_select !== 12'h000) begin errors++; $display("FAIL ill_done got v=%b e=%b sel=%h exp 1/1/000", rsp_valid, rsp_err, alu_select); end
        checks++; if (rsp_z !== '0 || rsp_hi !== '0 || rsp_lo !== '0 || rsp_wide !== 1'b0) begin errors++; $display("FAIL ill_data got z=%h hi=%h lo=%h w=%b exp 0", rsp_z, rsp_hi, rsp_lo, rsp_wide); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_stall();
        req_valid = 1'b1; req_op = 4'd1; req_a = 32'd124; req_b = 32'd7; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_z !== 32'd117 || req_ready !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL stall%0d got v=%b z=%0d r=%b e=%b exp 1/117/0/0", i, rsp_valid, rsp_z, req_ready, rsp_err); end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %b exp 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_op = 4'd6; req_a = 32'h7C; req_b = 32'h7; rsp_ready = 1'b1;
        tick();
        req_op = 4'd7;
        checks++; if (alu_select !== 12'h040 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_and_exec got sel=%h r=%b exp 040/0", alu_select, req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h4 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_and_rsp got v=%b z=%h r=%b exp 1/00000004/1", rsp_valid, rsp_z, req_ready); end
        tick();
        req_valid = 1'b0;
        checks++; if (alu_select !== 12'h080 || rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_or_exec got sel=%h v=%b exp 080/0", alu_select, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_z !== 32'h7F) begin errors++; $display("FAIL b2b_or_rsp got v=%b z=%h exp 1/0000007f", rsp_valid, rsp_z); end
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 4'd9; req_a = 32'd124; req_b = 32'd7; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            checks++; if (alu_select !== 12'h200 || rsp_valid !== 1'b0) begin errors++; $display("FAIL div_window%0d got sel=%h v=%b exp 200/0", i, alu_select, rsp_valid); end
            if (i < 10) tick();
        end
        #2;
        clr = 1'b0;
        #1;
        checks++; if (alu_select !== 12'h000 || alu_a !== '0 || alu_b !== '0) begin errors++; $display("FAIL mid_rst_alu got sel=%h a=%h b=%h exp 0", alu_select, alu_a, alu_b); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_z !== '0 || rsp_lo !== '0) begin errors++; $display("FAIL mid_rst_rsp got v=%b r=%b z=%h lo=%h exp 0", rsp_valid, req_ready, rsp_z, rsp_lo); end
        tick();
        clr = 1'b1;
        tick(); tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got v=%b r=%b exp 0/1", rsp_valid, req_ready); end
        req_valid = 1'b1; req_op = 4'd11; req_a = 32'h7C; req_b = 32'h0;
        tick();
        req_valid = 1'b0;
        checks++; if (alu_select !== 12'h800) begin errors++; $display("FAIL not_select got %h exp 800", alu_select); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_z !== 32'hFFFF_FF83 || rsp_wide !== 1'b0) begin errors++; $display("FAIL not_rsp got v=%b z=%h w=%b exp 1/ffffff83/0", rsp_valid, rsp_z, rsp_wide); end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
